// File: rtl/dlfloat16_div_sched.sv
// dlfloat16_div_sched: round-robin front end sharing one DLFloat16 divider
// between four requesters, with a single operation in flight at a time.
module dlfloat16_div_sched #(
    parameter int DIV_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [3:0]  req_ready,
    output logic [3:0]  div_ena,
    output logic [15:0] div_a,
    output logic [15:0] div_b,
    input  logic [19:0] div_c,
    input  logic [4:0]  div_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_id,
    output logic [19:0] resp_data,
    output logic [4:0]  resp_flags,
    output logic [4:0]  flags_sticky,
    input  logic        flags_clr,
    output logic        busy
);

    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_IDLE = 4'b0000;
    localparam logic [2:0] LAT     = 3'(DIV_LAT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]  last_grant;
    logic [1:0]  owner;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        pick_any;
    logic        grant;
    logic        capture;
    logic        resp_fire;
    logic [2:0]  cnt;
    logic [15:0] op_a;
    logic [15:0] op_b;

    // Scan from last_grant+4 down to last_grant+1 so the nearest
    // requester after the previous winner is the last one written.
    always_comb begin
        pick_any = 1'b0;
        pick     = last_grant;
        cand     = last_grant;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + 2'(k);
            if (req_valid[cand]) begin
                pick_any = 1'b1;
                pick     = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        capture   = 1'b0;
        resp_fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_fire = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The strobe is combinational, so mask it while reset is held.
    always_comb begin
        req_ready = 4'b0000;
        if (grant && !rst) begin
            req_ready[pick] = 1'b1;
        end
    end

    assign div_ena    = (state == ISSUE) ? OP_DIV : OP_IDLE;
    assign div_a      = (state == ISSUE) ? op_a : 16'h0000;
    assign div_b      = (state == ISSUE) ? op_b : 16'h0000;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 2'd3;
            owner      <= 2'd0;
            op_a       <= 16'h0000;
            op_b       <= 16'h0000;
            cnt        <= 3'd0;
            resp_id    <= 2'd0;
            resp_data  <= 20'h00000;
            resp_flags <= 5'b00000;
        end else begin
            if (grant) begin
                last_grant <= pick;
                owner      <= pick;
                op_a       <= req_a[{pick, 4'b0000} +: 16];
                op_b       <= req_b[{pick, 4'b0000} +: 16];
            end
            if (state == ISSUE) begin
                cnt <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                resp_data  <= div_c;
                resp_flags <= div_flags;
                resp_id    <= owner;
            end
        end
    end

    // A clear coinciding with a handshake still keeps the new flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_sticky <= 5'b00000;
        end else if (resp_fire) begin
            flags_sticky <= (flags_clr ? 5'b00000 : flags_sticky) | resp_flags;
        end else if (flags_clr) begin
            flags_sticky <= 5'b00000;
        end
    end

endmodule

// File: tb/tb_dlfloat16_div_sched.sv
// tb_dlfloat16_div_sched: randomized self-checking bench with a
// behavioural divider and round-robin/sticky-flag reference model.
module tb_dlfloat16_div_sched;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [63:0] req_a = 64'h0;
    logic [63:0] req_b = 64'h0;
    logic [3:0]  req_ready;
    logic [3:0]  div_ena;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic [19:0] div_c;
    logic [4:0]  div_flags;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_id;
    logic [19:0] resp_data;
    logic [4:0]  resp_flags;
    logic [4:0]  flags_sticky;
    logic        flags_clr = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_exp = 3;
    logic [4:0] sticky_exp = 5'b0;

    logic [15:0] m_a = 16'h0;
    logic [15:0] m_b = 16'h0;
    int          dcnt = 0;
    logic [19:0] junk_c = 20'h0;
    logic [4:0]  junk_f = 5'h0;

    dlfloat16_div_sched #(.DIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .div_ena(div_ena), .div_a(div_a), .div_b(div_b),
        .div_c(div_c), .div_flags(div_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_flags(resp_flags),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] divres(logic [15:0] a, logic [15:0] b);
        return {a ^ {b[7:0], b[15:8]}, a[3:0] ^ 4'hA};
    endfunction

    function automatic logic [4:0] divflg(logic [15:0] a, logic [15:0] b);
        if (a[14:0] == 15'h0 && b[14:0] == 15'h0) return 5'b10000;
        if (b[14:0] == 15'h0) return 5'b00001;
        return {1'b0, a[0] ^ b[0], a[1], b[1], 1'b0};
    endfunction

    function automatic int rr_pick(int last, logic [3:0] v);
        for (int i = 1; i <= 4; i++) begin
            if (v[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Divider model: result is valid only in the cycle whose closing
    // edge is LAT edges after the issue cycle; random junk otherwise.
    always @(negedge clk) begin
        junk_c <= 20'($urandom);
        junk_f <= 5'($urandom);
        if (rst) begin
            dcnt <= 0;
        end else if (div_ena == 4'b0011) begin
            m_a  <= div_a;
            m_b  <= div_b;
            dcnt <= LAT + 1;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end

    assign div_c     = (dcnt == 1) ? divres(m_a, m_b) : junk_c;
    assign div_flags = (dcnt == 1) ? divflg(m_a, m_b) : junk_f;

    task automatic txn(input logic [3:0] v, input logic [63:0] a,
                       input logic [63:0] b, input int hold, input logic clr,
                       output int gidx, output int lat, output logic [19:0] d,
                       output logic [4:0] f, output logic [1:0] id,
                       output bit ok, output bit stable);
        int n;
        int t0;
        ok = 0; stable = 1; gidx = -1; lat = -1;
        d = '0; f = '0; id = '0;
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b;
        #1;
        n = 0;
        while (req_ready === 4'b0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready === 4'b0) begin
            req_valid = 4'b0;
            return;
        end
        gidx = oh_idx(req_ready);
        t0 = cyc;
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (resp_valid !== 1'b1) return;
        ok = 1;
        lat = cyc - t0;
        d = resp_data; f = resp_flags; id = resp_id;
        repeat (hold) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== d ||
                resp_flags !== f || resp_id !== id) stable = 0;
        end
        resp_ready = 1'b1;
        flags_clr = clr;
        @(negedge clk);
        resp_ready = 1'b0;
        flags_clr = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if (req_ready !== 4'b0) begin
            bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready);
        end
        total++;
        if (div_ena !== 4'b0 || div_a !== 16'h0 || div_b !== 16'h0) begin
            bad++;
            $display("FAIL rst_div got=%b/%h/%h exp=0", div_ena, div_a, div_b);
        end
        total++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 ||
            resp_data !== 20'h0 || resp_flags !== 5'h0) begin
            bad++;
            $display("FAIL rst_resp got=%b/%h/%h/%h exp=0", resp_valid,
                     resp_id, resp_data, resp_flags);
        end
        total++;
        if (flags_sticky !== 5'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_sticky_busy got=%h/%b exp=0", flags_sticky, busy);
        end
        req_valid = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            bad++; $display("FAIL rst_release got=%b/%b exp=0", busy, req_ready);
        end
        last_exp = 3;
        sticky_exp = 5'b0;
    endtask

    task automatic test_fairness;
        int got[8];
        int n = 0;
        int k = 0;
        bit overlap = 0;
        int e;
        req_a = {$urandom, $urandom} | 64'h0100_0100_0100_0100;
        req_b = {$urandom, $urandom} | 64'h0100_0100_0100_0100;
        @(negedge clk);
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        #1;
        while (n < 8 && k < 200) begin
            if (req_ready !== 4'b0) begin
                got[n] = oh_idx(req_ready);
                if (resp_valid === 1'b1) overlap = 1;
                n++;
            end
            @(negedge clk); #1; k++;
        end
        req_valid = 4'b0;
        k = 0;
        while (busy === 1'b1 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        resp_ready = 1'b0;
        total++;
        if (n != 8 || busy !== 1'b0) begin
            bad++; $display("FAIL fair_timeout got=%0d grants exp=8", n);
        end
        for (int i = 0; i < n; i++) begin
            e = rr_pick(last_exp, 4'b1111);
            total++;
            if (got[i] != e) begin
                bad++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", i, got[i], e);
            end
            sticky_exp |= divflg(req_a[16*e +: 16], req_b[16*e +: 16]);
            last_exp = e;
        end
        total++;
        if (overlap) begin
            bad++; $display("FAIL fair_grant_in_resp got=1 exp=0");
        end
        total++;
        if (flags_sticky !== sticky_exp) begin
            bad++;
            $display("FAIL fair_sticky got=%b exp=%b", flags_sticky, sticky_exp);
        end
    endtask

    task automatic test_single;
        int t0;
        int n;
        logic [19:0] ed;
        logic [4:0] ef;
        ed = divres(16'h3E00, 16'h4000);
        ef = divflg(16'h3E00, 16'h4000);
        @(negedge clk);
        req_valid = 4'b0001;
        req_a = {48'h0, 16'h3E00};
        req_b = {48'h0, 16'h4000};
        #1;
        total++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_grant got=%b/%b exp=0001/0", req_ready, busy);
        end
        t0 = cyc;
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        total++;
        if (req_ready !== 4'b0) begin
            bad++; $display("FAIL single_ready_once got=%b exp=0000", req_ready);
        end
        total++;
        if (div_ena !== 4'b0011 || div_a !== 16'h3E00 ||
            div_b !== 16'h4000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_issue got=%b/%h/%h/%b exp=0011/3e00/4000/1",
                     div_ena, div_a, div_b, busy);
        end
        @(negedge clk); #1;
        total++;
        if (div_ena !== 4'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_ena_once got=%b/%b exp=0000/1", div_ena, busy);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (cyc - t0 != 2 + LAT) begin
            bad++; $display("FAIL single_latency got=%0d exp=%0d", cyc - t0, 2 + LAT);
        end
        total++;
        if (resp_id !== 2'd0 || resp_data !== ed || resp_flags !== ef) begin
            bad++;
            $display("FAIL single_resp got=%h/%h/%h exp=0/%h/%h",
                     resp_id, resp_data, resp_flags, ed, ef);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got=%b/%b exp=0/0", resp_valid, busy);
        end
        sticky_exp |= ef;
        last_exp = 0;
        total++;
        if (flags_sticky !== sticky_exp) begin
            bad++;
            $display("FAIL single_sticky got=%b exp=%b", flags_sticky, sticky_exp);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] d;
        logic [4:0] f;
        logic [1:0] id;
        int n = 0;
        bit moved = 0;
        bit leak = 0;
        a = 16'($urandom);
        b = 16'($urandom) | 16'h0100;
        @(negedge clk);
        req_valid = 4'b0100;
        req_a = {16'h0, a, 32'h0};
        req_b = {16'h0, b, 32'h0};
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL bp_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_timeout got=%b exp=1", resp_valid);
        end
        d = resp_data; f = resp_flags; id = resp_id;
        total++;
        if (d !== divres(a, b) || f !== divflg(a, b) || id !== 2'd2) begin
            bad++;
            $display("FAIL bp_resp got=%h/%h/%h exp=%h/%h/2",
                     d, f, id, divres(a, b), divflg(a, b));
        end
        repeat (5) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== d ||
                resp_flags !== f || resp_id !== id) moved = 1;
            if (req_ready !== 4'b0 || div_ena !== 4'b0) leak = 1;
        end
        total++;
        if (moved) begin
            bad++; $display("FAIL bp_stable got=changed exp=held");
        end
        total++;
        if (leak) begin
            bad++; $display("FAIL bp_no_grant got=activity exp=none");
        end
        resp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0) begin
            bad++; $display("FAIL bp_fire_grant got=%b exp=0000", req_ready);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 4'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got=%b exp=0", resp_valid);
        end
        sticky_exp |= divflg(a, b);
        last_exp = 2;
        total++;
        if (flags_sticky !== sticky_exp) begin
            bad++;
            $display("FAIL bp_sticky got=%b exp=%b", flags_sticky, sticky_exp);
        end
    endtask

    task automatic test_flags;
        int g;
        int lat;
        logic [19:0] d;
        logic [4:0] f;
        logic [1:0] id;
        bit ok;
        bit st;
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        sticky_exp = 5'b0;
        total++;
        if (flags_sticky !== 5'b0) begin
            bad++; $display("FAIL flg_clear got=%b exp=00000", flags_sticky);
        end
        txn(4'b0001, {48'h0, 16'h3E00}, 64'h0, 0, 1'b0, g, lat, d, f, id, ok, st);
        total++;
        if (!ok || f !== 5'b00001 || flags_sticky !== 5'b00001) begin
            bad++;
            $display("FAIL flg_dbz got=%b/%b exp=00001/00001", f, flags_sticky);
        end
        txn(4'b0001, 64'h0, 64'h0, 1, 1'b0, g, lat, d, f, id, ok, st);
        total++;
        if (!ok || f !== 5'b10000 || flags_sticky !== 5'b10001) begin
            bad++;
            $display("FAIL flg_nan got=%b/%b exp=10000/10001", f, flags_sticky);
        end
        txn(4'b0001, {48'h0, 16'h3E01}, {48'h0, 16'h4000}, 0, 1'b1,
            g, lat, d, f, id, ok, st);
        total++;
        if (!ok || f !== 5'b01000 || flags_sticky !== 5'b01000) begin
            bad++;
            $display("FAIL flg_clr_fire got=%b/%b exp=01000/01000", f, flags_sticky);
        end
        sticky_exp = 5'b01000;
        last_exp = 0;
    endtask

    task automatic test_random;
        logic [3:0] v;
        logic [63:0] a;
        logic [63:0] b;
        int hold;
        logic clr;
        int e;
        int g;
        int lat;
        logic [19:0] d;
        logic [4:0] f;
        logic [1:0] id;
        bit ok;
        bit st;
        logic [15:0] ea;
        logic [15:0] eb;
        for (int it = 0; it < 12; it++) begin
            v = 4'($urandom_range(1, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            hold = $urandom_range(0, 3);
            clr = ($urandom_range(0, 3) == 0);
            e = rr_pick(last_exp, v);
            ea = a[16*e +: 16];
            eb = b[16*e +: 16];
            txn(v, a, b, hold, clr, g, lat, d, f, id, ok, st);
            total++;
            if (!ok || g != e || id !== 2'(e)) begin
                bad++;
                $display("FAIL rnd_grant[%0d] got=%0d/%0d exp=%0d", it, g, id, e);
            end
            total++;
            if (lat != 2 + LAT) begin
                bad++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", it, lat, 2 + LAT);
            end
            total++;
            if (d !== divres(ea, eb) || f !== divflg(ea, eb)) begin
                bad++;
                $display("FAIL rnd_data[%0d] got=%h/%h exp=%h/%h",
                         it, d, f, divres(ea, eb), divflg(ea, eb));
            end
            total++;
            if (!st) begin
                bad++; $display("FAIL rnd_stable[%0d] got=changed exp=held", it);
            end
            sticky_exp = (clr ? 5'b0 : sticky_exp) | divflg(ea, eb);
            total++;
            if (flags_sticky !== sticky_exp || resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rnd_sticky[%0d] got=%b/%b exp=%b/0",
                         it, flags_sticky, resp_valid, sticky_exp);
            end
            last_exp = e;
        end
    endtask

    task automatic test_reset_wait;
        bit leak = 0;
        int g;
        int lat;
        logic [19:0] d;
        logic [4:0] f;
        logic [1:0] id;
        bit ok;
        bit st;
        @(negedge clk);
        req_valid = 4'b0010;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        #1;
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b1 || div_ena !== 4'b0) begin
            bad++; $display("FAIL rw_in_wait got=%b/%b exp=1/0000", busy, div_ena);
        end
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0 || div_ena !== 4'b0 || div_a !== 16'h0 ||
            div_b !== 16'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rw_ctrl got=%b/%b/%h/%h/%b exp=0",
                     req_ready, div_ena, div_a, div_b, busy);
        end
        total++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_data !== 20'h0 ||
            resp_flags !== 5'h0 || flags_sticky !== 5'h0) begin
            bad++;
            $display("FAIL rw_resp got=%b/%h/%h/%h/%h exp=0", resp_valid,
                     resp_id, resp_data, resp_flags, flags_sticky);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        req_valid = 4'b0;
        sticky_exp = 5'b0;
        last_exp = 3;
        repeat (8) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b0 || busy !== 1'b0) leak = 1;
        end
        total++;
        if (leak) begin
            bad++; $display("FAIL rw_no_resp got=activity exp=idle");
        end
        txn(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0,
            g, lat, d, f, id, ok, st);
        total++;
        if (!ok || g != rr_pick(last_exp, 4'b1111)) begin
            bad++; $display("FAIL rw_regrant got=%0d exp=0", g);
        end
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_backpressure;
        test_flags;
        test_random;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
